// File: rtl/riptide_irq_pkg.sv
// Shared definitions for the RIPTIDE-III interrupt controller: FSM states,
// register map and the priority helpers used by the controller.
package riptide_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FIRE  = 2'd2,
    ST_BLANK = 2'd3
  } irq_state_t;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_INSV = 2'd2;
  localparam logic [1:0] IRQ_CTRL = 2'd3;

  localparam int unsigned GIE_BIT = 0;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Index of the lowest set bit; 0 when v is empty.
  function automatic logic [2:0] prio_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[3'(7 - i)]) idx = 3'(7 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit 2-flop synchronizer followed by a registered rising-edge detector.
module irq_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= '0;
      sync   <= '0;
      sync_d <= '0;
      rise   <= '0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritized, maskable, nestable interrupt controller driving the PC's
// interrupt/int_addr inputs, with a MASK/PEND/INSV/CTRL register file.
module interrupt_controller
  import riptide_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               hazard,
  input  logic               branch_hazard,
  input  logic               p_cache_miss,
  input  logic               take_branch,
  input  logic               ret_exec,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata,
  output logic               interrupt,
  output logic [2:0]         int_addr,
  output logic               int_active
);

  irq_state_t state;

  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] insv;
  logic               gie;
  logic [2:0]         winner;
  logic [3:0]         blank_cnt;
  logic [NUM_SRC-1:0] rise;

  logic [NUM_SRC-1:0] below_insv;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ret_clr;
  logic [NUM_SRC-1:0] fire_set;
  logic [2:0]         cand;
  logic               cand_ok;
  logic               latched_ok;
  logic               safe;

  irq_sync_edge #(.WIDTH(NUM_SRC)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (irq),
    .rise     (rise)
  );

  // A source is eligible only if it outranks every level already in service.
  always_comb begin
    below_insv = (insv == '0) ? '1 : (lowest_onehot(insv) - 8'd1);
    eligible   = pend & mask & {NUM_SRC{gie}} & below_insv;
    cand_ok    = |eligible;
    cand       = prio_index(eligible);
    latched_ok = eligible[winner];
    safe       = ~(hazard | branch_hazard | p_cache_miss | take_branch);
    w1c        = (cfg_we && cfg_addr == IRQ_PEND) ? cfg_wdata : '0;
    ret_clr    = ret_exec ? lowest_onehot(insv) : '0;
    fire_set   = (state == ST_FIRE) ? (8'd1 << winner) : '0;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      IRQ_MASK: cfg_rdata = mask;
      IRQ_PEND: cfg_rdata = pend;
      IRQ_INSV: cfg_rdata = insv;
      default:  cfg_rdata[GIE_BIT] = gie;
    endcase
  end

  // New edges beat both W1C and the fire-time clear; RET clear precedes fire set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask       <= '0;
      pend       <= '0;
      insv       <= '0;
      gie        <= 1'b0;
      int_active <= 1'b0;
    end else begin
      pend       <= (pend & ~w1c & ~fire_set) | rise;
      insv       <= (insv & ~ret_clr) | fire_set;
      int_active <= |insv;
      if (cfg_we && cfg_addr == IRQ_MASK) mask <= cfg_wdata;
      if (cfg_we && cfg_addr == IRQ_CTRL) gie  <= cfg_wdata[GIE_BIT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      winner    <= '0;
      blank_cnt <= '0;
      interrupt <= 1'b0;
      int_addr  <= '0;
    end else begin
      interrupt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cand_ok) begin
            winner <= cand;
            state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (!latched_ok) begin
            state <= ST_IDLE;
          end else if (cand != winner) begin
            winner <= cand;
          end else if (safe) begin
            state     <= ST_FIRE;
            interrupt <= 1'b1;
            int_addr  <= winner;
          end
        end
        ST_FIRE: begin
          blank_cnt <= 4'(BLANK_CYCLES);
          state     <= (BLANK_CYCLES == 0) ? ST_IDLE : ST_BLANK;
        end
        ST_BLANK: begin
          blank_cnt <= blank_cnt - 4'd1;
          if (blank_cnt <= 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
